// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) reduction constant, state/word types,
// the inverse-mix-columns FSM encoding and small byte/word helpers.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned NUM_COLS    = 4;
    localparam int unsigned COL_CNT_W   = 2;

    // Low byte of x^8+x^4+x^3+x+1
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Column c lives in bits [127-32c -: 32]
    function automatic aes_word_t get_word(input aes_state_t s, input logic [COL_CNT_W-1:0] idx);
        aes_word_t w;
        case (idx)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic aes_state_t put_word(input aes_state_t s, input logic [COL_CNT_W-1:0] idx,
                                            input aes_word_t w);
        aes_state_t r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the MSB byte),
// built from xtime chains and XOR only.
//   col_in  : input column
//   col_out : transformed column
module inv_mix_column_word
    import aes_pkg::*;
(
    input  aes_word_t col_in,
    output aes_word_t col_out
);

    logic [7:0] a    [4];
    logic [7:0] m09  [4];
    logic [7:0] m0b  [4];
    logic [7:0] m0d  [4];
    logic [7:0] m0e  [4];

    // Per byte: x2, x4, x8 then combine into the four needed constants
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x2;
            logic [7:0] x4;
            logic [7:0] x8;
            a[i]   = col_in[31-8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m09[i] = x8 ^ a[i];
            m0b[i] = x8 ^ x2 ^ a[i];
            m0d[i] = x8 ^ x4 ^ a[i];
            m0e[i] = x8 ^ x4 ^ x2;
        end
    end

    assign col_out[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
    assign col_out[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
    assign col_out[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
    assign col_out[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];

endmodule

// File: rtl/inv_mix_columns_iter.sv
// AES InvMixColumns over a full 128-bit state with a valid/ready handshake.
// Default build: one shared column unit, one column per cycle (latency 4).
// INV_MIX_PARALLEL_EN: four column units, whole state at acceptance (latency 1).
//   CLK, RST            : clock, async active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from out_ready)
//   in_state            : input state, column c at [127-32c -: 32]
//   out_valid/out_ready : output handshake
//   out_state           : result, same layout, meaningful while out_valid=1
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_state
);

    imc_state_e               state_q, state_d;
    logic [COL_CNT_W-1:0]     col_cnt_q, col_cnt_d;
    aes_state_t               data_q, data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     accept_c;

`ifdef INV_MIX_PARALLEL_EN
    aes_state_t               par_state;

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
        inv_mix_column_word u_col (
            .col_in  (in_state[127-32*g -: 32]),
            .col_out (par_state[127-32*g -: 32])
        );
    end
`else
    aes_word_t                col_in;
    aes_word_t                col_out;
    logic [COL_CNT_W-1:0]     col_sel;

    // Acceptance transforms column 0 of the incoming state; BUSY walks data_q
    assign col_sel = accept_c ? COL_CNT_W'(0) : col_cnt_q;
    assign col_in  = get_word(accept_c ? aes_state_t'(in_state) : data_q, col_sel);

    inv_mix_column_word u_col (
        .col_in  (col_in),
        .col_out (col_out)
    );
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef INV_MIX_PARALLEL_EN
                if (accept_c) state_d = ST_DONE;
`else
                if (accept_c) state_d = ST_BUSY;
`endif
            end
            ST_BUSY: begin
`ifdef INV_MIX_PARALLEL_EN
                state_d = ST_IDLE;
`else
                if (col_cnt_q == COL_CNT_W'(NUM_COLS - 1)) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
`ifdef INV_MIX_PARALLEL_EN
                if (accept_c)       state_d = ST_DONE;
`else
                if (accept_c)       state_d = ST_BUSY;
`endif
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
        accept_c    = in_valid & in_ready;
        data_d      = data_q;
        col_cnt_d   = col_cnt_q;
        out_valid_d = (state_d == ST_DONE);
`ifdef INV_MIX_PARALLEL_EN
        col_cnt_d   = '0;
        if (accept_c) data_d = par_state;
`else
        if (accept_c) begin
            data_d    = put_word(aes_state_t'(in_state), COL_CNT_W'(0), col_out);
            col_cnt_d = COL_CNT_W'(1);
        end else if (state_q == ST_BUSY) begin
            data_d    = put_word(data_q, col_cnt_q, col_out);
            col_cnt_d = col_cnt_q + COL_CNT_W'(1);
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_cnt_q   <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = DATA_WIDTH'(data_q);

endmodule
